seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Iterative signed multiplier for the processor ALU. It computes `A*B` over `n` clock cycles using radix-2 shift-add on operand magnitudes, then applies a sign correction. It returns the low `n` bits with the same `out`/`overflow`/`car` flag convention as the ALU's combinational arithmetic units. It sits beside the divider in the ALU, and the control unit drives it through a start/busy/done handshake.

## Interface
- `n`, default 24: operand and result width in bits, two's complement.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous to `clk`, active-high.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `A`  in  n  signed multiplicand; captured on the accepted `start` edge.
- `B`  in  n  signed multiplier; captured on the accepted `start` edge.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; the result is valid.
- `out`  out  n  low `n` bits of the signed product; held until the next `done`.
- `overflow`  out  1  the signed product does not fit in `n` bits; held with `out`.
- `car`  out  1  tied to 0, matching the ALU flag convention.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - On `start=1`, register `|A|` and `|B|`, the result sign `A[n-1]^B[n-1]`, a 2n-bit accumulator cleared to 0, and iteration counter `n`. Go to RUN.
  - `A`/`B` are not sampled at any other time.
- RUN, once per cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1. Decrement the counter.
  - When the counter reaches 0, go to FIX.
- Magnitude of `-2^(n-1)` is `2^(n-1)`, held as an n-bit unsigned value. The accumulator is 2n bits unsigned, so no intermediate carry is lost.
- FIX:
  - P = sign ? -acc : acc, as a 2n-bit two's-complement value.
  - `out` <= P[n-1:0].
  - `overflow` <= 1 iff P[2n-1:n-1] is not all-zeros and not all-ones.
  - `done` <= 1. Go to IDLE.
- `start` while busy is ignored. It is not queued.
- Zero operands follow the normal path, with no early termination. The result is 0 and `overflow` is 0.

## Timing
- Reset (`rst` high at an edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `out`=0, `overflow`=0, `car`=0.
  - Reset takes priority over `start` and aborts any operation in flight. No `done` is produced for the aborted operation.
- Latency:
  - `start` sampled at edge k.
  - `busy`=1 from after edge k through edge k+n+1.
  - `done`=1 for exactly the cycle after edge k+n+1, with `busy`=0 in that cycle.
  - That is n+1 cycles from acceptance to result (25 for n=24).
- `out`/`overflow` update only at the FIX edge. They are stable before, during and after the `done` cycle until the next FIX.
- Back-to-back: `start` high during the `done` cycle is accepted, because the state is IDLE. The next `done` follows n+1 cycles later. Throughput is one result per n+1 cycles.
- Operand changes on `A`/`B` after acceptance have no effect on the result.

## Test plan
- Reset 2 cycles; check all outputs 0. Start `A=3`, `B=5`. Required: `done` exactly 25 cycles after the start edge, `out=0x00000F`, `overflow=0`, `car=0`, `busy` high 25 cycles.
- `A=-7` (0xFFFFF9), `B=6`: `out=0xFFFFD6`, `overflow=0`. Then `A=-0x800000`, `B=-1`: `out=0x800000`, `overflow=1`.
- `A=0x400000`, `B=2`: `out=0x800000`, `overflow=1`. Then `A=0x7FFFFF`, `B=0`: `out=0`, `overflow=0`.
- Start `A=100`, `B=200`. Pulse `start` again with `A=1`, `B=1` at cycle 10 and change `A`/`B` mid-run. Required: a single `done` at cycle 25 with `out=20000` (0x004E20); the second start is ignored.
- Start an operation, then assert `rst` at cycle 12. Required: `busy`/`done`/`out` are 0 on the next cycle and no `done` ever appears. A fresh start with `A=-3`, `B=-3` then yields `out=9`.
- Hold `start` high continuously with `A=2`, `B=-4`. Required: `done` every 25 cycles, `out=0xFFFFF8`, `busy` low only in `done` cycles. Run 100 random operand pairs against a 48-bit reference model for `out` and `overflow`.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative signed multiplier: radix-2 shift-add on operand magnitudes over n cycles,
// followed by a sign-correction cycle that produces the low n bits and the overflow flag.
module seq_multiplier #(
  parameter int n = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] out,
  output logic         overflow,
  output logic         car,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(n + 1);

  // Handshake: start is honoured only in IDLE; busy is high while RUN/FIX;
  // done pulses for one cycle (busy low) and out/overflow hold until the next done.
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [2*n-1:0]   mcand, acc, prod;
  logic [n-1:0]     mplier, a_mag, b_mag;
  logic [CW-1:0]    cnt;
  logic             sign;
  logic [n:0]       prod_hi;
  logic             ovf_nxt;

  // Magnitude of the most negative value wraps to 2^(n-1), which is correct as unsigned.
  assign a_mag   = A[n-1] ? (~A + 1'b1) : A;
  assign b_mag   = B[n-1] ? (~B + 1'b1) : B;
  assign prod    = sign ? (~acc + 1'b1) : acc;
  assign prod_hi = prod[2*n-1:n-1];
  assign ovf_nxt = !((prod_hi == '0) || (prod_hi == '1));

  assign busy      = (state != IDLE);
  assign car       = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      sign     <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{n{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            sign   <= A[n-1] ^ B[n-1];
            cnt    <= CW'(n);
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          out      <= prod[n-1:0];
          overflow <= ovf_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector and random bench for seq_multiplier (n = 24): latency, handshake,
// abort-by-reset, ignored start while busy, and product/overflow against a 48-bit model.
module tb_seq_multiplier;

  localparam int N = 24;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a_in, b_in;
  logic         busy, done, overflow, car;
  logic [N-1:0] out;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  seq_multiplier #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
    .busy(busy), .done(done), .out(out), .overflow(overflow), .car(car),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_out;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly one accepting edge; returns just after that edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from acceptance to the done cycle and busy-high cycles before it.
  task automatic wait_done(output int cyc, output int busy_cyc);
    busy_cyc = 0;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_cyc++;
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] m_out, output logic m_ovf);
    logic signed [47:0] sa, sb, p;
    sa = {{24{a[N-1]}}, a};
    sb = {{24{b[N-1]}}, b};
    p  = sa * sb;
    m_out = p[N-1:0];
    m_ovf = !((p[47:23] == 25'h0) || (p[47:23] == 25'h1FFFFFF));
  endtask

  initial begin
    int cyc, bcyc, ndone;
    logic [N-1:0] m_out, held;
    logic m_ovf, seen;

    vecs[0] = '{24'd3,        24'd5,        24'h00000F, 1'b0};
    vecs[1] = '{24'hFFFFF9,   24'd6,        24'hFFFFD6, 1'b0};
    vecs[2] = '{24'h800000,   24'hFFFFFF,   24'h800000, 1'b1};
    vecs[3] = '{24'h400000,   24'd2,        24'h800000, 1'b1};
    vecs[4] = '{24'h7FFFFF,   24'd0,        24'h000000, 1'b0};
    vecs[5] = '{24'hFFFFFD,   24'hFFFFFD,   24'h000009, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", out, 0);
    check("reset_ovf", overflow, 0);
    check("reset_car", car, 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(cyc, bcyc);
      check($sformatf("v%0d_latency", i), cyc, LAT);
      check($sformatf("v%0d_busy_cycles", i), bcyc, LAT);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
      check($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
      check($sformatf("v%0d_car", i), car, 0);
      tick();
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_out_held", i), out, vecs[i].exp_out);
    end

    // Start while busy is ignored; operand changes after acceptance have no effect
    launch(24'd100, 24'd200);
    held = out;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin start = 1'b1; a_in = 24'd1; b_in = 24'd1; end
      else begin start = 1'b0; a_in = 24'h123456; b_in = 24'h654321; end
      if (i == 12) check("mid_out_held", out, held);
      tick();
      if (done) begin cyc = i; break; end
    end
    start = 1'b0;
    check("ignore_latency", cyc, LAT);
    check("ignore_out", out, 24'h004E20);
    check("ignore_ovf", overflow, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("ignore_no_second_op", seen, 0);

    // Reset aborts an operation in flight
    launch(24'd50, 24'd60);
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_ovf", overflow, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    launch(24'hFFFFFD, 24'hFFFFFD);
    wait_done(cyc, bcyc);
    check("post_abort_latency", cyc, LAT);
    check("post_abort_out", out, 24'd9);

    // Continuous start: each done cycle is idle and the next op begins right after
    a_in = 24'd2; b_in = 24'hFFFFFC; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      check("cont_busy_vs_done", busy, !done);
      if (done) begin
        ndone++;
        check("cont_out", out, 24'hFFFFF8);
        check("cont_ovf", overflow, 0);
      end
    end
    start = 1'b0;
    check("cont_done_count_ge3", (ndone >= 3), 1);
    for (int i = 0; i < 40 && busy; i++) tick();
    tick();
    check("cont_idle", busy, 0);

    // Random operands against the 48-bit reference
    for (int i = 0; i < 100; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, 32'hFFFFFF));
      rb = N'($urandom_range(0, 32'hFFFFFF));
      if (i % 4 == 1) rb = N'($urandom_range(0, 255));
      if (i % 4 == 2) ra = {{12{ra[11]}}, ra[11:0]};
      model(ra, rb, m_out, m_ovf);
      launch(ra, rb);
      wait_done(cyc, bcyc);
      check($sformatf("rnd%0d_latency", i), cyc, LAT);
      check($sformatf("rnd%0d_out a=%h b=%h", i, ra, rb), out, m_out);
      check($sformatf("rnd%0d_ovf a=%h b=%h", i, ra, rb), overflow, m_ovf);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
